// File: rtl/rle_pixel_expander.sv
// Run-length pixel expander: turns 18-bit {colour, length-1} words from the
// flash reader into one pixel per active-display clock, with a 2-slot buffer.
// Ports: clk, rst (sync, active-high); instruction/instr_valid/shift_data =
// word handshake from the reader; pixel_en = display strobe; frame_start =
// underflow clear; rgb = registered pixel; underflow = sticky starvation
// flag; run_active = current slot holds a run.
module rle_pixel_expander #(
    parameter int COLOR_W = 6,
    parameter int LEN_W   = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COLOR_W+LEN_W-1:0] instruction,
    input  logic                     instr_valid,
    output logic                     shift_data,
    input  logic                     pixel_en,
    input  logic                     frame_start,
    output logic [COLOR_W-1:0]       rgb,
    output logic                     underflow,
    output logic                     run_active
);

    logic [COLOR_W-1:0] r_cur_color;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_cur_valid;
    logic [COLOR_W-1:0] r_nxt_color;
    logic [LEN_W-1:0]   r_nxt_len;
    logic               r_nxt_valid;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_underflow;

    logic w_capture;
    logic w_cur_ending;
    logic w_promote;
    logic w_starve;

    assign shift_data = !rst && !r_nxt_valid;
    assign w_capture  = instr_valid && shift_data;

    // The last pixel of the current run is going out this edge, so the
    // prefetched run can step in without leaving a gap pixel.
    assign w_cur_ending = r_cur_valid && pixel_en && (r_remaining == '0);
    assign w_promote    = r_nxt_valid && (!r_cur_valid || w_cur_ending);
    assign w_starve     = pixel_en && !r_cur_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_color <= '0;
            r_remaining <= '0;
            r_cur_valid <= 1'b0;
            r_nxt_color <= '0;
            r_nxt_len   <= '0;
            r_nxt_valid <= 1'b0;
            r_rgb       <= '0;
            r_underflow <= 1'b0;
        end else begin
            // Pixel output path
            if (pixel_en && r_cur_valid) begin
                r_rgb <= r_cur_color;
                if (r_remaining != '0) begin
                    r_remaining <= r_remaining - 1'b1;
                end
            end else begin
                r_rgb <= '0;
            end

            // Set takes priority over the frame clear
            if (w_starve) begin
                r_underflow <= 1'b1;
            end else if (frame_start) begin
                r_underflow <= 1'b0;
            end

            // Current slot: promotion overrides end-of-run
            if (w_promote) begin
                r_cur_color <= r_nxt_color;
                r_remaining <= r_nxt_len;
                r_cur_valid <= 1'b1;
            end else if (w_cur_ending) begin
                r_cur_valid <= 1'b0;
            end

            // Next slot: a new word always lands here, never straight in cur
            if (w_capture) begin
                r_nxt_color <= instruction[COLOR_W+LEN_W-1:LEN_W];
                r_nxt_len   <= instruction[LEN_W-1:0];
                r_nxt_valid <= 1'b1;
            end else if (w_promote) begin
                r_nxt_valid <= 1'b0;
            end
        end
    end

    assign rgb        = r_rgb;
    assign underflow  = r_underflow;
    assign run_active = r_cur_valid;

endmodule

// File: tb/tb_rle_pixel_expander.sv
// Directed self-checking bench for rle_pixel_expander.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_rle_pixel_expander;

    logic        clk;
    logic        rst;
    logic [17:0] instruction;
    logic        instr_valid;
    logic        shift_data;
    logic        pixel_en;
    logic        frame_start;
    logic [5:0]  rgb;
    logic        underflow;
    logic        run_active;

    int n_cmp = 0;
    int n_err = 0;

    rle_pixel_expander dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .shift_data  (shift_data),
        .pixel_en    (pixel_en),
        .frame_start (frame_start),
        .rgb         (rgb),
        .underflow   (underflow),
        .run_active  (run_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_run(input logic [17:0] w);
        instruction = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
    endtask

    logic [5:0] exp_seq [6];

    initial begin
        rst         = 1'b1;
        instruction = 18'h3F3FF;
        instr_valid = 1'b1;
        pixel_en    = 1'b0;
        frame_start = 1'b0;

        // Reset with valid held high
        #1;
        chk("rst_shift0", shift_data, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_rgb", rgb, 0);
            chk("rst_uf", underflow, 0);
            chk("rst_act", run_active, 0);
            chk("rst_shift", shift_data, 0);
        end
        rst = 1'b0;
        #1;
        chk("rel_shift", shift_data, 1);
        instr_valid = 1'b0;
        tick();
        chk("rel_nocap", shift_data, 1);

        // Single run: 0x2A, 3 pixels
        instruction = 18'h2A002;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("s_cap_shift", shift_data, 0);
        chk("s_cap_act", run_active, 0);
        tick();
        chk("s_pro_act", run_active, 1);
        chk("s_pro_shift", shift_data, 1);
        pixel_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s_rgb", rgb, 6'h2A);
            chk("s_uf", underflow, 0);
        end
        chk("s_end_act", run_active, 0);
        tick();
        chk("s_starve_rgb", rgb, 0);
        chk("s_starve_uf", underflow, 1);

        // Underflow clear, then coincident set wins
        pixel_en    = 1'b0;
        frame_start = 1'b1;
        tick();
        chk("uf_clr", underflow, 0);
        pixel_en = 1'b1;
        tick();
        chk("uf_setwins", underflow, 1);
        pixel_en = 1'b0;
        tick();
        chk("uf_clr2", underflow, 0);
        frame_start = 1'b0;

        // Back-to-back runs: 0x3F x1 then 0x15 x2
        instruction = 18'h3F000;
        instr_valid = 1'b1;
        tick();
        instruction = 18'h15001;
        tick();
        chk("b_pro_shift", shift_data, 1);
        chk("b_pro_act", run_active, 1);
        tick();
        instr_valid = 1'b0;
        chk("b_cap_shift", shift_data, 0);
        pixel_en = 1'b1;
        tick();
        chk("b_rgb0", rgb, 6'h3F);
        chk("b_act0", run_active, 1);
        chk("b_reshift", shift_data, 1);
        tick();
        chk("b_rgb1", rgb, 6'h15);
        tick();
        chk("b_rgb2", rgb, 6'h15);
        chk("b_act2", run_active, 0);
        pixel_en = 1'b0;
        tick();
        chk("b_blank", rgb, 0);
        chk("b_uf", underflow, 0);

        // Held valid: one capture only while current slot busy
        load_run(18'h01003);
        instruction = 18'h0C000;
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("h_shift", shift_data, 0);
            chk("h_act", run_active, 1);
        end
        instr_valid = 1'b0;
        exp_seq = '{6'h01, 6'h01, 6'h01, 6'h01, 6'h0C, 6'h00};
        pixel_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("h_rgb", rgb, exp_seq[i]);
        end
        chk("h_uf", underflow, 1);
        pixel_en    = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("h_clr", underflow, 0);

        // Blanking pause: 5 pixels of 0x33 interleaved with blanks
        load_run(18'h33004);
        for (int i = 0; i < 10; i++) begin
            pixel_en = (i % 2 == 0);
            tick();
            chk("p_rgb", rgb, (i % 2 == 0) ? 6'h33 : 6'h00);
            chk("p_uf", underflow, 0);
        end
        chk("p_done", run_active, 0);
        pixel_en = 1'b1;
        tick();
        chk("p_starve", underflow, 1);
        pixel_en = 1'b0;

        // Reset mid-run drops both slots
        load_run(18'h2200F);
        instruction = 18'h11001;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("m_act", run_active, 0);
        chk("m_uf", underflow, 0);
        chk("m_shift", shift_data, 1);
        pixel_en = 1'b1;
        tick();
        chk("m_rgb", rgb, 0);
        chk("m_starve", underflow, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rle_pixel_expander.md
Name: rle_pixel_expander

Overview:
- Sits directly downstream of the QSPI flash reader.
- Consumes its 18-bit run-length instructions (colour + run length) using a valid/shift_data handshake.
- Expands each run into one pixel per clock whenever the VGA timing block asserts active display.
- Holds a 2-slot buffer (current run + prefetched next run) so the flash stream can refill while pixels are emitted.

Parameters:
- COLOR_W, 6, colour field width (RGB222: [5:4]=R, [3:2]=G, [1:0]=B).
- LEN_W, 12, run-length field width. Encoded run length L gives L+1 pixels, so 1..4096.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- instruction  in  COLOR_W+LEN_W  run word. [17:12]=colour, [11:0]=run length minus 1.
- instr_valid  in  1  instruction holds a complete word. Either a one-cycle pulse or held high while the reader waits.
- shift_data  out  1  ready to the reader; high = next-slot empty, word may be taken.
- pixel_en  in  1  active-display pixel strobe from VGA timing; one pixel consumed per high cycle.
- frame_start  in  1  one-cycle pulse at start of each frame; clears the sticky underflow flag.
- rgb  out  COLOR_W  registered pixel colour.
- underflow  out  1  sticky: pixel_en arrived with no run loaded.
- run_active  out  1  current slot holds a run.

Behaviour:
- Reset (rst high at a clk edge) forces the following, regardless of other inputs:
  - rgb=0, underflow=0, run_active=0, cur_valid=0, nxt_valid=0, remaining=0.
  - shift_data=0 while rst is high.
- shift_data = !rst && !nxt_valid, combinational from registers only. It does not depend on instr_valid.
- Capture: when instr_valid && shift_data at a clk edge, store the colour/length into the next slot and set nxt_valid.
  - shift_data then drops on the following cycle.
  - A level-held instr_valid must not cause a second capture: the slot is full, so shift_data is low.
- Promotion (next slot to current slot) happens at an edge when the current slot is empty, or is emptying this cycle.
  - Loads cur_color, sets remaining = length field, sets cur_valid, clears nxt_valid.
  - Capture and promotion in the same cycle: promotion takes the old next-slot contents; the new word lands in the next slot.
  - Capture into an empty next slot while the current slot is also empty: the word lands in the next slot, then promotes on the following edge (1-cycle refill latency).
- Pixel emit: when pixel_en is high at an edge:
  - If cur_valid: rgb <= cur_color.
    - If remaining==0, the run ends: cur_valid clears unless promotion occurs in the same edge. Back-to-back runs must have no gap pixel.
    - Otherwise remaining decrements by 1.
  - If !cur_valid: rgb <= 0 and underflow <= 1.
- When pixel_en is low: rgb <= 0 (blanking) and remaining is held.
- Latency: pixel_en at edge N gives rgb valid after edge N, i.e. 1 cycle.
- frame_start clears underflow. If underflow sets in the same cycle, the set wins.
- run_active = cur_valid.
- Remaining-counter width is LEN_W. It never wraps, because a decrement only occurs when remaining is non-zero.
- rst mid-run discards both slots. The reader is reset by the same system reset.

Test Plan:
- Reset check: hold rst 2 cycles with instr_valid=1 -> rgb=0, underflow=0, run_active=0 and shift_data=0 throughout; shift_data=1 on the first cycle after release.
- Single run: word 0x2A_002 (colour 0x2A, L=2), pixel_en high for 4 cycles -> rgb=0x2A for 3 cycles, then 0 with underflow=1.
- Back-to-back runs: words {0x3F, L=0} then {0x15, L=1} preloaded, continuous pixel_en -> rgb sequence 0x3F, 0x15, 0x15 with no gap; shift_data re-asserts after each promotion.
- Held valid: instr_valid held high for 10 cycles with the same word, next slot initially empty -> exactly one capture; run_active=1 and shift_data=0 until that run promotes.
- Blanking pause: run L=4 with pixel_en toggling 1,0,1,0,... -> remaining only decrements on pixel_en cycles; 5 coloured pixels total, rgb=0 on every pixel_en=0 cycle.
- Underflow clear: underflow=1, then frame_start pulse -> underflow=0; frame_start coincident with an empty-slot pixel_en -> underflow stays 1.
